mips_dmem_mmio: RTL and testbench
=================================

# mips_dmem_mmio

Data-memory subsystem on the core's data port: word-addressed RAM plus a small memory-mapped I/O window.
- Consumes the core's memwrite/memaddr/writedata and returns readdata combinationally, so the single-cycle core sees zero-wait loads.
- MMIO window holds an output FIFO drained over a valid/ready stream, a status register and a free-running cycle counter.

## Interface
- DATA_MEM_WIDTH, 32, data/address width (from mips_pkg)
- MEM_DEPTH, 64, RAM depth in words (power of two)
- FIFO_DEPTH, 4, output FIFO depth in words (power of two, ≥2)

- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- memwrite  input  1  store strobe from core
- memaddr  input  DATA_MEM_WIDTH  byte address from core ALU
- writedata  input  DATA_MEM_WIDTH  store data
- readdata  output  DATA_MEM_WIDTH  load data, combinational from memaddr and current state
- out_data  output  DATA_MEM_WIDTH  FIFO head word
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  sink accepts head this cycle

## Operation
- Region decode:
  - memaddr[31]=0 is RAM.
  - memaddr[31]=1 is MMIO.
  - memaddr[1:0] ignored everywhere (word accesses only).
- RAM:
  - Index = memaddr[log2(MEM_DEPTH)+1:2]; higher bits ignored, so addresses alias modulo MEM_DEPTH words.
  - Write on clock edge when memwrite=1.
  - All words cleared to 0 on reset.
- MMIO map (offset = memaddr[3:2]; memaddr[30:4] ignored):
  - 0 TXDATA: write pushes writedata into FIFO; read returns 0.
  - 1 STATUS: read {27'b0, count[2:0], overflow, full}, with count saturating at 7 for display. Write with writedata[2]=1 clears overflow; other bits are read-only.
  - 2 CYCLE: read returns counter. Write loads writedata.
  - 3 reserved: reads 0, writes ignored.
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count of log2(FIFO_DEPTH)+1 bits.
  - full = (count==FIFO_DEPTH).
  - Pop occurs when out_valid && out_ready.
  - Push request occurs when memwrite && TXDATA is addressed.
  - A push is accepted if !full, or if a pop happens the same cycle.
  - Push while full and not popping: data dropped, overflow set (sticky).
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - out_valid = (count!=0).
  - out_data = head word when valid, else 0.
- Cycle counter:
  - 32 bits, increments by 1 every cycle; wraps 0xFFFF_FFFF → 0.
  - A CYCLE write loads writedata, overriding that cycle's increment; the next cycle reads writedata+1.

## Timing
- Reset (async assert, sync-safe deassert): RAM=0, FIFO empty, pointers=0, overflow=0, counter=0.
- Outputs in reset: readdata=0 for any address except STATUS. out_valid=0, out_data=0.
- Load latency 0: readdata is combinational from memaddr, RAM, FIFO state and counter.
- A store and a load of the same address in the same cycle return the old value; the new value is visible from the next cycle.
- FIFO push-to-out_valid latency: 1 cycle (valid rises the cycle after the accepted push edge).
- Pop: head advances at the edge where out_valid&&out_ready. out_data may change only after a pop or after a push into an empty FIFO.
- out_valid never drops without a pop.
- Reset asserted mid-stream discards FIFO contents immediately; out_valid falls asynchronously.
- Pointer wrap: pointers roll FIFO_DEPTH-1 → 0 with no bubble.
- No combinational path from out_ready to readdata, out_valid or out_data.

## Test plan
- Reset then RAM: store 0xDEADBEEF @0x10, load @0x10 → 0xDEADBEEF. Load @0x110 (alias, MEM_DEPTH=64) → 0xDEADBEEF. Load @0x14 → 0.
- FIFO ordering: out_ready=0, push 1,2,3,4. STATUS → full=1, count=4. Raise out_ready → out_data 1,2,3,4 on consecutive cycles, then out_valid=0.
- Overflow: fill FIFO, push 5 with out_ready=0 → dropped, STATUS overflow=1. Write STATUS 0x4 → overflow=0; FIFO contents intact.
- Full with simultaneous push/pop: FIFO full, out_ready=1, push 9 → count stays 4, no overflow, 9 emerges fourth.
- Counter: 10 cycles after reset CYCLE reads 10. Write 0xFFFF_FFFE, next cycle reads 0xFFFF_FFFF, then 0.
- Reset mid-operation: FIFO holding 3 words, pulse rst_n low → out_valid=0 immediately. STATUS → 0. RAM reads 0.

Source files
------------

// File: rtl/mips_dmem_mmio.sv
// Data memory for the single-cycle core: word RAM below 0x8000_0000, MMIO window above.
// Latency: loads are combinational (zero wait), stores and FIFO pushes/pops commit on the rising edge.
// Backpressure: output FIFO drains on out_valid && out_ready; pushes into a full, non-draining FIFO drop and set a sticky overflow.
module mips_dmem_mmio #(
    parameter int DATA_MEM_WIDTH = 32,
    parameter int MEM_DEPTH      = 64,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      memwrite,
    input  logic [DATA_MEM_WIDTH-1:0] memaddr,
    input  logic [DATA_MEM_WIDTH-1:0] writedata,
    output logic [DATA_MEM_WIDTH-1:0] readdata,
    output logic [DATA_MEM_WIDTH-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;

    logic [DATA_MEM_WIDTH-1:0] r_ram [MEM_DEPTH];
    logic [DATA_MEM_WIDTH-1:0] r_buf [FIFO_DEPTH];
    logic [PW-1:0]             r_rd_ptr;
    logic [PW-1:0]             r_wr_ptr;
    logic [CW-1:0]             r_count;
    logic                      r_overflow;
    logic [DATA_MEM_WIDTH-1:0] r_cycle;

    logic                      w_is_mmio;
    logic [1:0]                w_off;
    logic [AW-1:0]             w_ram_idx;
    logic                      w_ram_we;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_push_req;
    logic                      w_push;
    logic                      w_status_we;
    logic                      w_cycle_we;
    logic [31:0]               w_cnt_ext;
    logic [2:0]                w_cnt_disp;
    logic [DATA_MEM_WIDTH-1:0] w_status;
    logic                      w_unused_addr;

    // Address decode: bit 31 selects region, [1:0] ignored, RAM aliases modulo MEM_DEPTH.
    assign w_is_mmio   = memaddr[DATA_MEM_WIDTH-1];
    assign w_off       = memaddr[3:2];
    assign w_ram_idx   = memaddr[AW+1:2];
    assign w_unused_addr = ^{memaddr[DATA_MEM_WIDTH-2:AW+2], memaddr[1:0]};

    assign w_ram_we    = memwrite && !w_is_mmio;
    assign w_push_req  = memwrite && w_is_mmio && (w_off == OFF_TXDATA);
    assign w_status_we = memwrite && w_is_mmio && (w_off == OFF_STATUS);
    assign w_cycle_we  = memwrite && w_is_mmio && (w_off == OFF_CYCLE);

    // FIFO handshake: pop only depends on registered state and out_ready, never feeds readdata.
    assign out_valid = (r_count != '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_pop     = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign out_data  = out_valid ? r_buf[r_rd_ptr] : '0;

    // STATUS count field is only 3 bits wide, so clamp deeper FIFOs at 7.
    assign w_cnt_ext  = 32'(r_count);
    assign w_cnt_disp = (w_cnt_ext > 32'd7) ? 3'd7 : w_cnt_ext[2:0];
    assign w_status   = {{(DATA_MEM_WIDTH-5){1'b0}}, w_cnt_disp, r_overflow, w_full};

    // RAM: cleared on reset, one word written per store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_ram[i] <= '0;
            end
        end else if (w_ram_we) begin
            r_ram[w_ram_idx] <= writedata;
        end
    end

    // FIFO storage: contents need no reset because out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= writedata;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky overflow: set by a dropped push, cleared by writing STATUS with bit 2 set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && !w_push) begin
            r_overflow <= 1'b1;
        end else if (w_status_we && writedata[2]) begin
            r_overflow <= 1'b0;
        end
    end

    // Free-running cycle counter. A written value counts as the value of the write
    // cycle itself, so the register steps past it and the next cycle reads value+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle <= '0;
        end else if (w_cycle_we) begin
            r_cycle <= writedata + 1'b1;
        end else begin
            r_cycle <= r_cycle + 1'b1;
        end
    end

    // Load mux: purely from the address and registered state.
    always_comb begin
        readdata = '0;
        if (!w_is_mmio) begin
            readdata = r_ram[w_ram_idx];
        end else begin
            case (w_off)
                OFF_STATUS: readdata = w_status;
                OFF_CYCLE:  readdata = r_cycle;
                default:    readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem_mmio.sv
// Directed bench for mips_dmem_mmio: table of per-cycle vectors plus hand sequences
// for reset state, the cycle counter and reset in mid-stream.
module tb_mips_dmem_mmio;

    localparam logic [31:0] A_TX = 32'h8000_0000;
    localparam logic [31:0] A_ST = 32'h8000_0004;
    localparam logic [31:0] A_CY = 32'h8000_0008;
    localparam logic [31:0] A_RS = 32'h8000_000C;

    logic        clk;
    logic        rst_n;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int total;
    int bad;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] exp_rd;
        logic        exp_vld;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[$];

    mips_dmem_mmio #(
        .DATA_MEM_WIDTH(32),
        .MEM_DEPTH(64),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .memwrite(memwrite),
        .memaddr(memaddr),
        .writedata(writedata),
        .readdata(readdata),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic rdy);
        memwrite  = we;
        memaddr   = addr;
        writedata = wd;
        out_ready = rdy;
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic rdy, input logic [31:0] exp_rd,
                                input logic exp_vld, input logic [31:0] exp_dat);
        vec_t v;
        v.we = we; v.addr = addr; v.wd = wd; v.rdy = rdy;
        v.exp_rd = exp_rd; v.exp_vld = exp_vld; v.exp_dat = exp_dat;
        return v;
    endfunction

    initial begin
        total = 0;
        bad   = 0;

        // Inputs change at the falling edge and are checked 1ns later, i.e. on the
        // state left by the previous rising edge.
        // RAM store/load, aliasing, same-cycle store returns old value.
        vecs.push_back(mk(1, 32'h10,  32'hDEADBEEF, 0, 32'h0,        0, 0));
        vecs.push_back(mk(0, 32'h10,  0, 0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 32'h110, 0, 0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 32'h13,  0, 0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 32'h14,  0, 0, 32'h0,        0, 0));
        vecs.push_back(mk(0, A_TX,    0, 0, 32'h0,        0, 0));
        // Fill FIFO with 1..4, valid one cycle after the first push.
        vecs.push_back(mk(1, A_TX, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, A_TX, 2, 0, 0, 1, 1));
        vecs.push_back(mk(1, A_TX, 3, 0, 0, 1, 1));
        vecs.push_back(mk(1, A_TX, 4, 0, 0, 1, 1));
        vecs.push_back(mk(0, A_ST, 0, 0, 32'h11, 1, 1));
        // Overflow: drop 5, clear with STATUS bit 2.
        vecs.push_back(mk(1, A_TX, 5, 0, 0,      1, 1));
        vecs.push_back(mk(0, A_ST, 0, 0, 32'h13, 1, 1));
        vecs.push_back(mk(1, A_ST, 4, 0, 32'h13, 1, 1));
        vecs.push_back(mk(0, A_ST, 0, 0, 32'h11, 1, 1));
        vecs.push_back(mk(0, 32'hFFFF_FFF4, 0, 0, 32'h11, 1, 1));
        vecs.push_back(mk(1, A_RS, 32'h123, 0, 0, 1, 1));
        vecs.push_back(mk(0, A_RS, 0, 0, 0, 1, 1));
        // Drain: contents intact after overflow, one word per cycle.
        vecs.push_back(mk(0, 32'h10, 0, 1, 32'hDEADBEEF, 1, 1));
        vecs.push_back(mk(0, 32'h10, 0, 1, 32'hDEADBEEF, 1, 2));
        vecs.push_back(mk(0, 32'h10, 0, 1, 32'hDEADBEEF, 1, 3));
        vecs.push_back(mk(0, 32'h10, 0, 1, 32'hDEADBEEF, 1, 4));
        vecs.push_back(mk(0, A_ST,   0, 1, 32'h0, 0, 0));
        // Full with simultaneous push/pop, across pointer wrap.
        vecs.push_back(mk(1, A_TX, 5, 0, 0, 0, 0));
        vecs.push_back(mk(1, A_TX, 6, 0, 0, 1, 5));
        vecs.push_back(mk(1, A_TX, 7, 0, 0, 1, 5));
        vecs.push_back(mk(1, A_TX, 8, 0, 0, 1, 5));
        vecs.push_back(mk(1, A_TX, 9, 1, 0, 1, 5));
        vecs.push_back(mk(0, A_ST, 0, 0, 32'h11, 1, 6));
        vecs.push_back(mk(0, A_ST, 0, 1, 32'h11, 1, 6));
        vecs.push_back(mk(0, A_ST, 0, 1, 32'h0C, 1, 7));
        vecs.push_back(mk(0, A_ST, 0, 1, 32'h08, 1, 8));
        vecs.push_back(mk(0, A_ST, 0, 1, 32'h04, 1, 9));
        vecs.push_back(mk(0, A_ST, 0, 0, 32'h00, 0, 0));

        // Reset state.
        rst_n = 1'b0;
        drive(0, 32'h10, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ram",   readdata, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_data",  out_data, 32'h0);
        memaddr = A_CY;
        #1;
        check("rst_cycle", readdata, 32'h0);

        // Cycle counter: 10 edges after release reads 10, then load and wrap.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        check("cycle_10", readdata, 32'd10);
        drive(1, A_CY, 32'hFFFF_FFFE, 0);
        @(negedge clk);
        drive(0, A_CY, 0, 0);
        #1;
        check("cycle_load", readdata, 32'hFFFF_FFFF);
        @(negedge clk);
        #1;
        check("cycle_wrap", readdata, 32'h0);
        @(negedge clk);
        #1;
        check("cycle_after_wrap", readdata, 32'h1);

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].rdy);
            #1;
            check($sformatf("v%0d_rd",  i), readdata, vecs[i].exp_rd);
            check($sformatf("v%0d_vld", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_vld});
            check($sformatf("v%0d_dat", i), out_data, vecs[i].exp_dat);
        end

        // Reset mid-stream with three words queued.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, A_TX, 32'(10 * (k + 1)), 0);
        end
        @(negedge clk);
        drive(0, A_ST, 0, 0);
        #1;
        check("mid_status", readdata, 32'h0C);
        check("mid_valid",  {31'b0, out_valid}, 32'h1);
        check("mid_data",   out_data, 32'd10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  {31'b0, out_valid}, 32'h0);
        check("mid_rst_data",   out_data, 32'h0);
        check("mid_rst_status", readdata, 32'h0);
        memaddr = 32'h10;
        #1;
        check("mid_rst_ram", readdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_valid", {31'b0, out_valid}, 32'h0);
        check("post_rst_ram",   readdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
